// File: rtl/proc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the AR/T datapath.
// Owns the instruction register, PC, fetch timeout, halt/fault status and retire count.
module proc_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              stop,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              reg_write,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [CNT_W-1:0]  retired
);

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [4:0] OP_AR   = 5'b00000;
  localparam logic [4:0] OP_T    = 5'b00001;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ILLEGAL = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED,
    ST_FAULT
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [31:0]       instr_reg, instr_next;
  logic [CNT_W-1:0]  retired_reg, retired_next;
  logic [TO_W-1:0]   tcnt_reg, tcnt_next;
  logic [1:0]        fault_code_reg, fault_code_next;
  logic [4:0]        opcode;

  assign opcode = instr_reg[31:27];

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    retired_next    = retired_reg;
    tcnt_next       = tcnt_reg;
    fault_code_next = fault_code_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          tcnt_next  = '0;
          state_next = ST_DECODE;
        end else if (tcnt_reg == TO_W'(TIMEOUT - 1)) begin
          // This was the last permitted wait cycle; an ack here would still have won.
          tcnt_next       = '0;
          fault_code_next = FC_TIMEOUT;
          state_next      = ST_FAULT;
        end else begin
          tcnt_next = tcnt_reg + TO_W'(1);
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_AR, OP_T: state_next = ST_EXECUTE;
          OP_HALT:     state_next = ST_HALTED;
          default: begin
            fault_code_next = FC_ILLEGAL;
            state_next      = ST_FAULT;
          end
        endcase
      end
      ST_EXECUTE: begin
        state_next = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_next = pc_reg + ADDR_W'(1);
        if (retired_reg != {CNT_W{1'b1}}) retired_next = retired_reg + CNT_W'(1);
        state_next = stop ? ST_IDLE : ST_FETCH;
      end
      ST_HALTED: state_next = ST_HALTED;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= ADDR_W'(RESET_PC);
      instr_reg      <= '0;
      retired_reg    <= '0;
      tcnt_reg       <= '0;
      fault_code_reg <= FC_NONE;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      retired_reg    <= retired_next;
      tcnt_reg       <= tcnt_next;
      fault_code_reg <= fault_code_next;
    end
  end

  // Write strobe is masked by reset so a reset landing in WRITEBACK commits nothing.
  assign reg_write  = (state_reg == ST_WRITEBACK) && !RESET;
  assign imem_req   = (state_reg == ST_FETCH);
  assign imem_addr  = imem_req ? pc_reg : '0;
  assign busy       = (state_reg == ST_FETCH) || (state_reg == ST_DECODE) ||
                      (state_reg == ST_EXECUTE) || (state_reg == ST_WRITEBACK);
  assign halted     = (state_reg == ST_HALTED);
  assign fault      = (state_reg == ST_FAULT);
  assign fault_code = fault_code_reg;
  assign instr      = instr_reg;
  assign pc         = pc_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: a per-cycle vector table for an AR/T/HALT
// program plus hand-written sequences for wait states, timeout, illegal opcode, wrap and reset.
module tb_proc_sequencer;

  logic        CLK;
  logic        RESET;
  logic        start, stop;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        reg_write, busy, halted, fault;
  logic [15:0] pc;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  logic        start1, stop1;
  logic        req1, ack1;
  logic [3:0]  addr1;
  logic [31:0] rdata1;
  logic [31:0] instr1;
  logic        rw1, busy1, halted1, fault1;
  logic [3:0]  pc1;
  logic [1:0]  fcode1;
  logic [1:0]  retired1;

  int checks = 0;
  int errors = 0;

  proc_sequencer dut (
    .CLK(CLK), .RESET(RESET), .start(start), .stop(stop),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .reg_write(reg_write), .pc(pc),
    .busy(busy), .halted(halted), .fault(fault), .fault_code(fault_code),
    .retired(retired)
  );

  proc_sequencer #(.ADDR_W(4), .RESET_PC(15), .TIMEOUT(15), .CNT_W(2)) dut1 (
    .CLK(CLK), .RESET(RESET), .start(start1), .stop(stop1),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1),
    .imem_rdata(rdata1), .instr(instr1), .reg_write(rw1), .pc(pc1),
    .busy(busy1), .halted(halted1), .fault(fault1), .fault_code(fcode1),
    .retired(retired1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory responder: ack after ack_delay wait cycles of a held request.
  logic [31:0] mem [16];
  int ack_delay = 0;
  int wait_cnt  = 0;
  always @(negedge CLK) begin
    if (imem_req) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr[3:0]];
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(negedge CLK) ack1 = req1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    start  = 1'b0;
    stop   = 1'b0;
    start1 = 1'b0;
    stop1  = 1'b0;
    RESET  = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  typedef struct {
    logic        start;
    logic        stop;
    logic        req;
    logic        rw;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [15:0] pc;
    logic [31:0] retired;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(logic s, logic p, logic rq, logic w, logic b, logic h,
                              logic f, logic [15:0] epc, logic [31:0] ret, logic [31:0] ins);
    vec_t v;
    v.start = s; v.stop = p; v.req = rq; v.rw = w; v.busy = b; v.halted = h;
    v.fault = f; v.pc = epc; v.retired = ret; v.instr = ins;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic rw_seen;

    imem_ack   = 1'b0;
    imem_rdata = '0;
    ack1       = 1'b0;
    rdata1     = 32'h0000_0000;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h0800_0000;
    mem[2] = 32'hF800_0000;

    // AR @0, T @1, HALT @2 with zero-wait memory, one row per cycle after the edge
    vecs[0]  = mk(1, 0, 1, 0, 1, 0, 0, 16'd0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 1, 1, 0, 0, 16'd0, 0, 32'h0);
    vecs[4]  = mk(0, 0, 1, 0, 1, 0, 0, 16'd1, 1, 32'h0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 0, 0, 16'd1, 1, 32'h0800_0000);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0, 0, 16'd1, 1, 32'h0800_0000);
    vecs[7]  = mk(0, 0, 0, 1, 1, 0, 0, 16'd1, 1, 32'h0800_0000);
    vecs[8]  = mk(0, 0, 1, 0, 1, 0, 0, 16'd2, 2, 32'h0800_0000);
    vecs[9]  = mk(0, 0, 0, 0, 1, 0, 0, 16'd2, 2, 32'hF800_0000);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, 16'd2, 2, 32'hF800_0000);
    vecs[11] = mk(1, 0, 0, 0, 0, 1, 0, 16'd2, 2, 32'hF800_0000);
    vecs[12] = mk(1, 1, 0, 0, 0, 1, 0, 16'd2, 2, 32'hF800_0000);

    do_reset();
    chk("rst_pc", pc, 16'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 16'h0);
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_fault_code", fault_code, 2'd0);
    chk("rst_pc_wide_dut1", pc1, 4'd15);

    for (int i = 0; i < 13; i++) begin
      start = vecs[i].start;
      stop  = vecs[i].stop;
      tick();
      $display("vec %0d: req=%0b rw=%0b busy=%0b halted=%0b pc=%0d retired=%0d instr=%08h",
               i, imem_req, reg_write, busy, halted, pc, retired, instr);
      chk($sformatf("vec%0d_req", i), imem_req, vecs[i].req);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].req ? vecs[i].pc : 16'h0);
      chk($sformatf("vec%0d_reg_write", i), reg_write, vecs[i].rw);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_halted", i), halted, vecs[i].halted);
      chk($sformatf("vec%0d_fault", i), fault, vecs[i].fault);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      chk($sformatf("vec%0d_retired", i), retired, vecs[i].retired);
      chk($sformatf("vec%0d_instr", i), instr, vecs[i].instr);
    end

    // Ack after 3 wait cycles: write-back lands on cycle 7
    do_reset();
    ack_delay = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!reg_write && cyc < 30) begin
      tick();
      cyc++;
    end
    $display("ack delay 3: reg_write at cycle %0d", cyc);
    chk("ack3_retire_cycle", cyc, 7);
    stop = 1'b1;
    tick();
    chk("ack3_pc", pc, 16'd1);
    chk("ack3_stop_idle", busy, 1'b0);

    // No ack for TIMEOUT cycles -> fetch timeout fault
    do_reset();
    ack_delay = 1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk("to_cycle15_fault", fault, 1'b0);
    chk("to_cycle15_req", imem_req, 1'b1);
    tick();
    $display("timeout: fault=%0b code=%0d req=%0b pc=%0d", fault, fault_code, imem_req, pc);
    chk("to_fault", fault, 1'b1);
    chk("to_fault_code", fault_code, 2'd2);
    chk("to_req_drop", imem_req, 1'b0);
    chk("to_pc", pc, 16'd0);
    chk("to_busy", busy, 1'b0);
    start = 1'b1;
    tick();
    tick();
    chk("to_sticky", fault, 1'b1);
    start = 1'b0;

    // Ack on exactly the TIMEOUT-th fetch cycle is accepted
    do_reset();
    ack_delay = 14;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!reg_write && !fault && cyc < 40) begin
      tick();
      cyc++;
    end
    $display("ack on cycle 15: reg_write at cycle %0d fault=%0b", cyc, fault);
    chk("to_edge_retire_cycle", cyc, 18);
    chk("to_edge_no_fault", fault, 1'b0);

    // Illegal opcode 5'b00101
    do_reset();
    ack_delay = 0;
    mem[0] = 32'h2800_0000;
    rw_seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    rw_seen |= reg_write;
    tick();
    rw_seen |= reg_write;
    chk("ill_decode_instr", instr, 32'h2800_0000);
    tick();
    rw_seen |= reg_write;
    tick();
    rw_seen |= reg_write;
    $display("illegal: fault=%0b code=%0d retired=%0d rw_seen=%0b", fault, fault_code, retired, rw_seen);
    chk("ill_fault", fault, 1'b1);
    chk("ill_fault_code", fault_code, 2'd1);
    chk("ill_no_reg_write", rw_seen, 1'b0);
    chk("ill_retired", retired, 32'h0);
    chk("ill_pc", pc, 16'd0);

    // Narrow instance: PC wraps 15 -> 0 and stop returns to IDLE after one instruction
    do_reset();
    start1 = 1'b1;
    stop1  = 1'b1;
    tick();
    start1 = 1'b0;
    chk("wrap_fetch_addr", addr1, 4'd15);
    tick();
    tick();
    tick();
    chk("wrap_wb_rw", rw1, 1'b1);
    tick();
    $display("wrap: pc=%0d busy=%0b retired=%0d", pc1, busy1, retired1);
    chk("wrap_pc", pc1, 4'd0);
    chk("wrap_idle", busy1, 1'b0);
    chk("wrap_retired", retired1, 2'd1);
    tick();
    tick();
    chk("wrap_stays_idle", req1, 1'b0);

    // Retired count saturates at all-ones
    start1 = 1'b1;
    stop1  = 1'b0;
    tick();
    start1 = 1'b0;
    repeat (20) tick();
    stop1 = 1'b1;
    repeat (4) tick();
    $display("saturate: retired=%0d pc=%0d", retired1, pc1);
    chk("sat_retired", retired1, 2'd3);
    chk("sat_idle", busy1, 1'b0);

    // Reset landing in WRITEBACK
    do_reset();
    ack_delay = 0;
    mem[0] = 32'h0800_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("rwb_pre_rw", reg_write, 1'b1);
    chk("rwb_pre_instr", instr, 32'h0800_0000);
    RESET = 1'b1;
    #1;
    chk("rwb_rw_masked", reg_write, 1'b0);
    tick();
    RESET = 1'b0;
    $display("reset in writeback: busy=%0b pc=%0d instr=%08h retired=%0d", busy, pc, instr, retired);
    chk("rwb_busy", busy, 1'b0);
    chk("rwb_pc", pc, 16'd0);
    chk("rwb_instr", instr, 32'h0);
    chk("rwb_retired", retired, 32'h0);
    chk("rwb_rw", reg_write, 1'b0);
    tick();
    chk("rwb_idle_after", busy, 1'b0);

    // Reset during a fetch wait, with the ack arriving in the reset cycle
    ack_delay = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    $display("reset in fetch: busy=%0b req=%0b pc=%0d instr=%08h", busy, imem_req, pc, instr);
    chk("rf_instr", instr, 32'h0);
    chk("rf_busy", busy, 1'b0);
    chk("rf_pc", pc, 16'd0);
    tick();
    chk("rf_req", imem_req, 1'b0);
    chk("rf_fault", fault, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
